id_stage_reg: RTL

ID/EX pipeline register of the five-stage ARM core. It captures the decoded control bits from the control unit, along with operands, immediates, destination and PC, at the end of the ID stage, and presents them to the EX stage for one cycle. It provides:
- hold behaviour for memory stalls,
- bubble insertion for branch flush and data hazards,
- saturating debug counters for flushes and bubbles.

---
 rtl/id_stage_reg_if.sv | 75 +++++++
 rtl/id_stage_reg.sv | 110 +++++++++++
 2 files changed

// File: rtl/id_stage_reg_if.sv
// ID/EX pipeline register bus: decoded instruction fields entering from ID,
// the registered copy presented to EX, stall/flush/hazard controls and the
// debug counters. The pipeline register owns the slave side.
interface id_stage_reg_if #(
    parameter int EXE_CMD_LEN = 4,
    parameter int CNT_LEN     = 16
);
    // Pipeline controls
    logic                   freeze;
    logic                   flush;
    logic                   hazard;

    // Fields captured at the end of ID
    logic                   wb_en_in;
    logic                   mem_r_en_in;
    logic                   mem_w_en_in;
    logic                   b_in;
    logic                   s_in;
    logic                   imm_in;
    logic [EXE_CMD_LEN-1:0] exe_cmd_in;
    logic [31:0]            pc_in;
    logic [31:0]            val_rn_in;
    logic [31:0]            val_rm_in;
    logic [11:0]            shift_operand_in;
    logic [23:0]            signed_imm_24_in;
    logic [3:0]             dest_in;
    logic [3:0]             src1_in;
    logic [3:0]             src2_in;
    logic [3:0]             status_in;

    // Registered fields presented to EX
    logic                   wb_en_out;
    logic                   mem_r_en_out;
    logic                   mem_w_en_out;
    logic                   b_out;
    logic                   s_out;
    logic                   imm_out;
    logic [EXE_CMD_LEN-1:0] exe_cmd_out;
    logic [31:0]            pc_out;
    logic [31:0]            val_rn_out;
    logic [31:0]            val_rm_out;
    logic [11:0]            shift_operand_out;
    logic [23:0]            signed_imm_24_out;
    logic [3:0]             dest_out;
    logic [3:0]             src1_out;
    logic [3:0]             src2_out;
    logic [3:0]             status_out;
    logic                   valid_out;
    logic [CNT_LEN-1:0]     flush_count;
    logic [CNT_LEN-1:0]     bubble_count;

    // Upstream/control side: drives ID fields and controls, observes EX side
    modport master (
        output freeze, flush, hazard,
        output wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
        output exe_cmd_in, pc_in, val_rn_in, val_rm_in, shift_operand_in,
        output signed_imm_24_in, dest_in, src1_in, src2_in, status_in,
        input  wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out,
        input  exe_cmd_out, pc_out, val_rn_out, val_rm_out, shift_operand_out,
        input  signed_imm_24_out, dest_out, src1_out, src2_out, status_out,
        input  valid_out, flush_count, bubble_count
    );

    // Pipeline register side
    modport slave (
        input  freeze, flush, hazard,
        input  wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
        input  exe_cmd_in, pc_in, val_rn_in, val_rm_in, shift_operand_in,
        input  signed_imm_24_in, dest_in, src1_in, src2_in, status_in,
        output wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out,
        output exe_cmd_out, pc_out, val_rn_out, val_rm_out, shift_operand_out,
        output signed_imm_24_out, dest_out, src1_out, src2_out, status_out,
        output valid_out, flush_count, bubble_count
    );
endinterface

// File: rtl/id_stage_reg.sv
// ID/EX pipeline register. Holds on freeze, loads a bubble on flush or
// hazard, otherwise captures the decoded instruction. Two saturating debug
// counters record how many flushes and hazard bubbles were taken.
module id_stage_reg #(
    parameter int EXE_CMD_LEN = 4,
    parameter int CNT_LEN     = 16
) (
    input  logic         clk,
    input  logic         rst,
    id_stage_reg_if.slave bus
);

    typedef struct packed {
        logic                   wb_en;
        logic                   mem_r_en;
        logic                   mem_w_en;
        logic                   b;
        logic                   s;
        logic                   imm;
        logic [EXE_CMD_LEN-1:0] exe_cmd;
        logic [31:0]            pc;
        logic [31:0]            val_rn;
        logic [31:0]            val_rm;
        logic [11:0]            shift_operand;
        logic [23:0]            signed_imm_24;
        logic [3:0]             dest;
        logic [3:0]             src1;
        logic [3:0]             src2;
        logic [3:0]             status;
    } id_ex_t;

    localparam logic [CNT_LEN-1:0] CNT_MAX = '1;

    id_ex_t             w_in;
    id_ex_t             r_pl;
    logic               r_valid;
    logic [CNT_LEN-1:0] r_flush_count;
    logic [CNT_LEN-1:0] r_bubble_count;

    // Gather the incoming ID fields into one record
    always_comb begin
        // NOTE: every field is assigned on every evaluation, so no latch can be inferred.
        w_in.wb_en         = bus.wb_en_in;
        w_in.mem_r_en      = bus.mem_r_en_in;
        w_in.mem_w_en      = bus.mem_w_en_in;
        w_in.b             = bus.b_in;
        w_in.s             = bus.s_in;
        w_in.imm           = bus.imm_in;
        w_in.exe_cmd       = bus.exe_cmd_in;
        w_in.pc            = bus.pc_in;
        w_in.val_rn        = bus.val_rn_in;
        w_in.val_rm        = bus.val_rm_in;
        w_in.shift_operand = bus.shift_operand_in;
        w_in.signed_imm_24 = bus.signed_imm_24_in;
        w_in.dest          = bus.dest_in;
        w_in.src1          = bus.src1_in;
        w_in.src2          = bus.src2_in;
        w_in.status        = bus.status_in;
    end

    // Pipeline register: reset > freeze > flush > hazard > load
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            r_pl           <= '0;
            r_valid        <= 1'b0;
            r_flush_count  <= '0;
            r_bubble_count <= '0;
        end else if (!bus.freeze) begin
            if (bus.flush) begin
                // A flush wins over a simultaneous hazard; only its counter moves
                r_pl    <= '0;
                r_valid <= 1'b0;
                if (r_flush_count != CNT_MAX) begin
                    r_flush_count <= r_flush_count + CNT_LEN'(1);
                end
            end else if (bus.hazard) begin
                r_pl    <= '0;
                r_valid <= 1'b0;
                if (r_bubble_count != CNT_MAX) begin
                    r_bubble_count <= r_bubble_count + CNT_LEN'(1);
                end
            end else begin
                r_pl    <= w_in;
                r_valid <= 1'b1;
            end
        end
    end

    assign bus.wb_en_out         = r_pl.wb_en;
    assign bus.mem_r_en_out      = r_pl.mem_r_en;
    assign bus.mem_w_en_out      = r_pl.mem_w_en;
    assign bus.b_out             = r_pl.b;
    assign bus.s_out             = r_pl.s;
    assign bus.imm_out           = r_pl.imm;
    assign bus.exe_cmd_out       = r_pl.exe_cmd;
    assign bus.pc_out            = r_pl.pc;
    assign bus.val_rn_out        = r_pl.val_rn;
    assign bus.val_rm_out        = r_pl.val_rm;
    assign bus.shift_operand_out = r_pl.shift_operand;
    assign bus.signed_imm_24_out = r_pl.signed_imm_24;
    assign bus.dest_out          = r_pl.dest;
    assign bus.src1_out          = r_pl.src1;
    assign bus.src2_out          = r_pl.src2;
    assign bus.status_out        = r_pl.status;
    assign bus.valid_out         = r_valid;
    assign bus.flush_count       = r_flush_count;
    assign bus.bubble_count      = r_bubble_count;

endmodule
